// File: rtl/vector_scale_add_mc.sv
// Multi-cycle vector scale-add: P[i] = Y[i] +/- w*X[i], LANES elements per pass.
// Optional: define VSAD_SATURATE_EN to clamp out-of-range results and flag them on ovf.
module vector_scale_add_mc #(
   parameter int unsigned LENGTH     = 5,
   parameter int unsigned LANES      = 1,
   parameter int unsigned MUL_STAGES = 3
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  sclr,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  sub,
   input  logic [31:0]           w,
   input  logic [32*LENGTH-1:0]  X,
   input  logic [64*LENGTH-1:0]  Y,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [64*LENGTH-1:0]  P,
   output logic [LENGTH-1:0]     ovf
);

   localparam int unsigned PASSES = (LENGTH + LANES - 1) / LANES;
   localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
`ifdef VSAD_SATURATE_EN
   localparam int unsigned SW     = 65;
`else
   localparam int unsigned SW     = 64;
`endif

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [PW-1:0]        pass_q, pass_d;
   logic                 accept, issue, last_pass;

   logic signed [31:0]   w_q;
   logic [32*LENGTH-1:0] x_q;
   logic [64*LENGTH-1:0] y_q;
   logic                 sub_q;

   logic [MUL_STAGES-1:0] vld_q, vld_d;
   logic [PW-1:0]         pass_pipe_q [MUL_STAGES];
   logic signed [63:0]    prod_q [MUL_STAGES][LANES];
   logic signed [31:0]    mul_x [LANES];

   logic signed [SW-1:0]  sum_e [LENGTH];
   logic [LENGTH-1:0]     wb_e;
   logic [63:0]           p_q [LENGTH];
   logic [63:0]           p_d [LENGTH];

   assign in_ready  = ce && (state_q == IDLE);
   assign accept    = in_valid && in_ready;
   assign issue     = (state_q == RUN);
   assign last_pass = (pass_q == PW'(PASSES - 1));
   assign out_valid = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               pass_d  = '0;
            end
         end
         RUN: begin
            if (last_pass) state_d = DRAIN;
            else           pass_d  = pass_q + 1'b1;
         end
         DRAIN: begin
            if (!(|vld_q)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = issue;
   end

   // Route each element of the current pass onto its lane; idle lanes multiply zero.
   always_comb begin
      for (int l = 0; l < LANES; l++) mul_x[l] = '0;
      for (int i = 0; i < LENGTH; i++) begin
         if (pass_q == PW'(i / LANES)) mul_x[i % LANES] = $signed(x_q[32*i +: 32]);
      end
   end

   always_comb begin
      for (int i = 0; i < LENGTH; i++) begin
         wb_e[i] = vld_q[MUL_STAGES-1] && (pass_pipe_q[MUL_STAGES-1] == PW'(i / LANES));
         if (sub_q) begin
            sum_e[i] = SW'($signed(y_q[64*i +: 64])) - SW'(prod_q[MUL_STAGES-1][i % LANES]);
         end else begin
            sum_e[i] = SW'($signed(y_q[64*i +: 64])) + SW'(prod_q[MUL_STAGES-1][i % LANES]);
         end
         p_d[i] = p_q[i];
         if (wb_e[i]) begin
`ifdef VSAD_SATURATE_EN
            if (sum_e[i][64] != sum_e[i][63]) begin
               p_d[i] = sum_e[i][64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            end else begin
               p_d[i] = sum_e[i][63:0];
            end
`else
            p_d[i] = sum_e[i][63:0];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         pass_q  <= '0;
         vld_q   <= '0;
         for (int i = 0; i < LENGTH; i++) p_q[i] <= '0;
      end else if (sclr) begin
         state_q <= IDLE;
         pass_q  <= '0;
         vld_q   <= '0;
         for (int i = 0; i < LENGTH; i++) p_q[i] <= '0;
      end else if (ce) begin
         state_q <= state_d;
         pass_q  <= pass_d;
         vld_q   <= vld_d;
         p_q     <= p_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         w_q   <= $signed(w);
         x_q   <= X;
         y_q   <= Y;
         sub_q <= sub;
      end
   end

   // Multiplier bank: product formed at issue, then carried MUL_STAGES-1 more stages.
   always_ff @(posedge clk) begin
      if (ce) begin
         for (int l = 0; l < LANES; l++) prod_q[0][l] <= 64'(w_q) * 64'(mul_x[l]);
         pass_pipe_q[0] <= pass_q;
         for (int s = 1; s < MUL_STAGES; s++) begin
            prod_q[s]      <= prod_q[s-1];
            pass_pipe_q[s] <= pass_pipe_q[s-1];
         end
      end
   end

`ifdef VSAD_SATURATE_EN
   logic [LENGTH-1:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (accept) ovf_d = '0;
      for (int i = 0; i < LENGTH; i++) begin
         if (wb_e[i] && (sum_e[i][64] != sum_e[i][63])) ovf_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)  ovf_q <= '0;
      else if (sclr) ovf_q <= '0;
      else if (ce)   ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   assign ovf = '0;
`endif

   for (genvar i = 0; i < LENGTH; i++) begin : g_p
      assign P[64*i +: 64] = p_q[i];
   end

endmodule

// File: tb/tb_vector_scale_add_mc.sv
// Self-checking bench for vector_scale_add_mc (LENGTH=5, LANES=2, MUL_STAGES=3).
// Results are predicted with plain wide-integer arithmetic per element.
module tb_vector_scale_add_mc;

   localparam int unsigned LENGTH     = 5;
   localparam int unsigned LANES      = 2;
   localparam int unsigned MUL_STAGES = 3;
   localparam int          PASSES     = (LENGTH + LANES - 1) / LANES;
   localparam int          LAT        = PASSES + MUL_STAGES + 1;

   logic                  clk = 1'b0;
   logic                  aresetn, sclr, ce, in_valid, in_ready, sub, out_valid, out_ready;
   logic [31:0]           w;
   logic [32*LENGTH-1:0]  X;
   logic [64*LENGTH-1:0]  Y, P;
   logic [LENGTH-1:0]     ovf;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_p   [LENGTH];
   logic        exp_ovf [LENGTH];
   logic [63:0] prev_p  [LENGTH];
   logic [63:0] spec1   [LENGTH];

   vector_scale_add_mc #(
      .LENGTH     (LENGTH),
      .LANES      (LANES),
      .MUL_STAGES (MUL_STAGES)
   ) dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .sclr      (sclr),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sub       (sub),
      .w         (w),
      .X         (X),
      .Y         (Y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .P         (P),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   // Exact result in 128 bits, then clamp or wrap into 64.
   function automatic logic [63:0] model(input logic [31:0] wv, input logic [31:0] xv,
                                         input logic [63:0] yv, input logic sv,
                                         output logic ov);
      logic signed [127:0] e;
      longint              prod;
      prod = longint'($signed(wv)) * longint'($signed(xv));
      e    = $signed(yv);
      e    = sv ? e - prod : e + prod;
      ov   = (e > 128'sh7FFF_FFFF_FFFF_FFFF) || (e < -128'sh8000_0000_0000_0000);
`ifdef VSAD_SATURATE_EN
      if (ov) return (e < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`else
      ov = 1'b0;
`endif
      return e[63:0];
   endfunction

   task automatic clear_expect();
      for (int i = 0; i < LENGTH; i++) begin
         exp_p[i]   = '0;
         exp_ovf[i] = 1'b0;
      end
   endtask

   task automatic start_vec(input logic [31:0] wv, input logic [32*LENGTH-1:0] xv,
                            input logic [64*LENGTH-1:0] yv, input logic sv);
      int t;
      for (int i = 0; i < LENGTH; i++) begin
         prev_p[i] = exp_p[i];
         exp_p[i]  = model(wv, xv[32*i +: 32], yv[64*i +: 64], sv, exp_ovf[i]);
      end
      w = wv; X = xv; Y = yv; sub = sv; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      check("accept_ready", in_ready, 1);
      @(posedge clk); #1;
      // Scramble the operand bus so only latched values can produce the result.
      in_valid = 1'b0;
      w = $urandom;
      for (int i = 0; i < LENGTH; i++) begin
         X[32*i +: 32] = $urandom;
         Y[64*i +: 64] = {$urandom, $urandom};
      end
      sub = ~sv;
      for (int i = 0; i < LENGTH; i++) check("hold_prev", P[64*i +: 64], prev_p[i]);
      check("ovf_clear", ovf, 0);
   endtask

   task automatic wait_done(input int stall_at, input int stall_len);
      int edges;
      edges = 0;
      while (!out_valid && edges < 60) begin
         if (edges == stall_at && stall_len > 0) begin
            ce = 1'b0;
            repeat (stall_len) begin
               in_valid = 1'b1;
               @(posedge clk); #1;
               edges++;
               check("stall_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            ce = 1'b1;
         end else begin
            @(posedge clk); #1;
            edges++;
         end
      end
      check("latency", edges, LAT + stall_len);
      check("out_valid", out_valid, 1);
      for (int i = 0; i < LENGTH; i++) begin
         check("p", P[64*i +: 64], exp_p[i]);
         check("ovf", ovf[i], exp_ovf[i]);
      end
   endtask

   task automatic finish_vec(input int hold);
      out_ready = 1'b0;
      repeat (hold) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         check("bp_ready", in_ready, 0);
         check("bp_valid", out_valid, 1);
         for (int i = 0; i < LENGTH; i++) check("bp_p", P[64*i +: 64], exp_p[i]);
         check("bp_ovf", ovf, {exp_ovf[4], exp_ovf[3], exp_ovf[2], exp_ovf[1], exp_ovf[0]});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("done_drop", out_valid, 0);
      check("idle_ready", in_ready, 1);
      out_ready = 1'b0;
   endtask

   task automatic rand_operands(output logic [31:0] wv, output logic [32*LENGTH-1:0] xv,
                                output logic [64*LENGTH-1:0] yv, output logic sv);
      int big;
      big = $urandom_range(0, 1);
      wv  = $urandom;
      sv  = 1'($urandom_range(0, 1));
      for (int i = 0; i < LENGTH; i++) begin
         xv[32*i +: 32] = $urandom;
         yv[64*i +: 64] = {$urandom, $urandom};
         if (big == 0) yv[64*i +: 64] = $signed(yv[64*i +: 64]) >>> 12;
      end
   endtask

   initial begin
      logic [31:0]          rw;
      logic [32*LENGTH-1:0] rx;
      logic [64*LENGTH-1:0] ry;
      logic                 rs;

      spec1 = '{64'h00000002_40000000, 64'h00000000_80000000, 64'h0000000C_E0000000,
                64'h00000064_80000000, 64'hFFFFFFFF_C0000000};
      aresetn = 1'b0; sclr = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      sub = 1'b0; w = '0; X = '0; Y = '0;
      clear_expect();
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_p", P[63:0] | P[127:64] | P[191:128] | P[255:192] | P[319:256], 0);
      check("rst_ovf", ovf, 0);
      aresetn = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", in_ready, 1);

      // Reference vector, unstalled, then with a RUN stall and DONE backpressure.
      start_vec(32'h0000_8000,
                {32'hffff_8000, 32'h0000_0000, 32'h0019_c000, 32'h0001_0000, 32'h0004_8000},
                {64'h0, 64'h00000064_80000000, 64'h0, 64'h0, 64'h0}, 1'b0);
      wait_done(-1, 0);
      for (int i = 0; i < LENGTH; i++) check("spec_p", P[64*i +: 64], spec1[i]);
      finish_vec(0);

      start_vec(32'h0000_8000,
                {32'hffff_8000, 32'h0000_0000, 32'h0019_c000, 32'h0001_0000, 32'h0004_8000},
                {64'h0, 64'h00000064_80000000, 64'h0, 64'h0, 64'h0}, 1'b0);
      wait_done(2, 4);
      finish_vec(10);

      // Add then subtract on a short operand set.
      start_vec(32'h0000_4000, {32'h0, 32'h0, 32'h0, 32'h0, 32'hfff1_8000},
                {64'h0, 64'h0, 64'h0, 64'h00000004_00000000, 64'h0}, 1'b0);
      wait_done(-1, 0);
      check("spec_add0", P[63:0], 64'hFFFFFFFC_60000000);
      check("spec_add1", P[127:64], 64'h00000004_00000000);
      finish_vec(1);
      start_vec(32'h0000_4000, {32'h0, 32'h0, 32'h0, 32'h0, 32'hfff1_8000},
                {64'h0, 64'h0, 64'h0, 64'h00000004_00000000, 64'h0}, 1'b1);
      wait_done(-1, 0);
      check("spec_sub0", P[63:0], 64'h00000003_A0000000);
      finish_vec(0);

      // Positive overflow of element 0.
      start_vec(32'h7FFF_0000, {32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFF_0000},
                {64'h0, 64'h0, 64'h0, 64'h0, 64'h7FFFFFFF_00000000}, 1'b0);
      wait_done(-1, 0);
      finish_vec(2);

      for (int n = 0; n < 12; n++) begin
         rand_operands(rw, rx, ry, rs);
         start_vec(rw, rx, ry, rs);
         if ($urandom_range(0, 1) == 1) wait_done($urandom_range(0, LAT - 1), $urandom_range(1, 3));
         else                           wait_done(-1, 0);
         finish_vec($urandom_range(0, 3));
      end

      // Asynchronous reset mid-RUN aborts and clears P.
      rand_operands(rw, rx, ry, rs);
      start_vec(rw, rx, ry, rs);
      @(posedge clk); #2;
      aresetn = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_p", P[63:0] | P[127:64] | P[191:128] | P[255:192] | P[319:256], 0);
      #2;
      aresetn = 1'b1;
      clear_expect();
      rand_operands(rw, rx, ry, rs);
      start_vec(rw, rx, ry, rs);
      wait_done(-1, 0);
      finish_vec(0);

      // Synchronous clear in DONE wins over ce low.
      rand_operands(rw, rx, ry, rs);
      start_vec(rw, rx, ry, rs);
      wait_done(-1, 0);
      ce = 1'b0;
      sclr = 1'b1;
      @(posedge clk); #1;
      check("sclr_valid", out_valid, 0);
      check("sclr_p", P[63:0] | P[127:64] | P[191:128] | P[255:192] | P[319:256], 0);
      check("sclr_ovf", ovf, 0);
      sclr = 1'b0;
      ce = 1'b1;
      #1;
      check("sclr_idle", in_ready, 1);
      clear_expect();
      rand_operands(rw, rx, ry, rs);
      start_vec(rw, rx, ry, rs);
      wait_done(-1, 0);
      finish_vec(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1);
   end

endmodule
